mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl_pkg.sv | 32 +++
 rtl/mux_scan_ctrl_if.sv | 13 +
 rtl/mux_scan_ctrl_chan_next.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;

  typedef logic [SEL_W-1:0] chan_idx_t;

  localparam chan_idx_t CH_A = 2'd0;
  localparam chan_idx_t CH_B = 2'd1;
  localparam chan_idx_t CH_C = 2'd2;
  localparam chan_idx_t CH_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DWELL   = 3'd4
  } scan_state_e;

  // Lowest enabled channel of a mask; CH_A when the mask is empty.
  function automatic chan_idx_t lowest_chan(input logic [NUM_CH-1:0] m);
    chan_idx_t r;
    r = CH_A;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = chan_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Sample handshake between the scan controller (master) and its consumer (slave).
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic            smp_valid;
  logic            smp_ready;
  logic            smp_data;
  logic [SEL_W-1:0] smp_chan;

  modport master (output smp_valid, output smp_data, output smp_chan, input smp_ready);
  modport slave  (input smp_valid, input smp_data, input smp_chan, output smp_ready);

endinterface

// File: rtl/mux_scan_ctrl_chan_next.sv
// Combinational next-channel search: first enabled channel after cur,
// wrapping 3 -> 0. wrap is set when the search had to go round past the
// top, i.e. cur was the highest enabled channel.
module scan_chan_next
  import mux_scan_ctrl_pkg::*;
(
  input  chan_idx_t         cur,
  input  logic [NUM_CH-1:0] mask,
  output chan_idx_t         nxt,
  output logic              wrap
);

  chan_idx_t cand;
  logic      found;

  // Scan the three following channels, then cur itself (single-channel case).
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = cur;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = chan_idx_t'(int'(cur) + i);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: steps the select lines over the
// enabled channels, waits for the mux to settle, captures mux_out and hands
// it to the consumer over a valid/ready handshake.
// Optional build macro MUX_SCAN_FRAME_EN adds frame_vec/frame_done, a
// per-frame snapshot of the accepted samples.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | not scanning; select lines hold their last value
// ST_SETTLE  | select just changed, waiting SETTLE_CYC cycles for the mux
// ST_CAPTURE | mux_out is sampled at the end of this cycle
// ST_HOLD    | sample presented, waiting for smp_ready
// ST_DWELL   | dwell cycles between acceptance and the next select change
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  mux_scan_ctrl_if.master    smp
`ifdef MUX_SCAN_FRAME_EN
  ,
  output logic [NUM_CH-1:0]  frame_vec,
  output logic               frame_done
`endif
);

  // One counter serves both settle and dwell timing.
  localparam int              CNT_W       = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  scan_state_e       state;
  chan_idx_t         sel;
  logic [NUM_CH-1:0] mask_lat;
  logic [CNT_W-1:0]  cnt;
  logic              stop_pend;
  logic              busy_q;
  logic              valid_q;
  logic              data_q;
  chan_idx_t         chan_q;

  chan_idx_t         nxt_idx;
  logic              nxt_wrap;
  chan_idx_t         adv_sel;
  logic [NUM_CH-1:0] adv_mask;
  logic              adv_go;
  logic              start_go;
  logic              accept;
  logic              stop_eff;

  scan_chan_next u_chan_next (
    .cur  (sel),
    .mask (mask_lat),
    .nxt  (nxt_idx),
    .wrap (nxt_wrap)
  );

  // Where the select goes on the next advance; a wrap re-latches the mask.
  always_comb begin
    adv_go   = 1'b1;
    adv_sel  = nxt_idx;
    adv_mask = mask_lat;
    if (nxt_wrap) begin
      adv_mask = chan_mask;
      adv_sel  = lowest_chan(chan_mask);
      adv_go   = |chan_mask;
    end
  end

  // Stop in the same cycle as start wins; an empty mask never starts a scan.
  assign start_go = start && !stop && (|chan_mask);
  assign accept   = (state == ST_HOLD) && valid_q && smp.smp_ready;
  assign stop_eff = stop || stop_pend;

  // Main scan sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= CH_A;
      mask_lat  <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 1'b0;
      chan_q    <= CH_A;
    end else begin
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (start_go) begin
            sel      <= lowest_chan(chan_mask);
            mask_lat <= chan_mask;
            cnt      <= SETTLE_LOAD;
            busy_q   <= 1'b1;
            state    <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (stop_eff) begin
            stop_pend <= 1'b0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          if (stop_eff) begin
            stop_pend <= 1'b0;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            data_q  <= mux_out;
            chan_q  <= sel;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // A sample is held, so stop waits for its acceptance.
          if (stop) stop_pend <= 1'b1;
          if (accept) begin
            valid_q <= 1'b0;
            if (stop_eff) begin
              stop_pend <= 1'b0;
              busy_q    <= 1'b0;
              state     <= ST_IDLE;
            end else if (dwell == '0) begin
              mask_lat <= adv_mask;
              if (adv_go) begin
                sel   <= adv_sel;
                cnt   <= SETTLE_LOAD;
                state <= ST_SETTLE;
              end else begin
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end
            end else begin
              cnt   <= CNT_W'(dwell) - CNT_W'(1);
              state <= ST_DWELL;
            end
          end
        end

        ST_DWELL: begin
          if (stop_eff) begin
            stop_pend <= 1'b0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt == '0) begin
            mask_lat <= adv_mask;
            if (adv_go) begin
              sel   <= adv_sel;
              cnt   <= SETTLE_LOAD;
              state <= ST_SETTLE;
            end else begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign {s1, s0}      = sel;
  assign busy          = busy_q;
  assign smp.smp_valid = valid_q;
  assign smp.smp_data  = data_q;
  assign smp.smp_chan  = chan_q;

`ifdef MUX_SCAN_FRAME_EN
  logic [NUM_CH-1:0] frame_acc;
  logic [NUM_CH-1:0] acc_upd;

  // Accumulator with the sample being accepted merged in.
  always_comb begin
    acc_upd         = frame_acc;
    acc_upd[chan_q] = data_q;
  end

  // Collect accepted samples; publish the frame when the top channel is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_acc  <= '0;
      frame_vec  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if ((state == ST_IDLE) && start_go) begin
        frame_acc <= '0;
      end else if (accept) begin
        if (nxt_wrap) begin
          frame_vec  <= acc_upd;
          frame_done <= 1'b1;
          frame_acc  <= '0;
        end else begin
          frame_acc <= acc_upd;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl. The mux is modelled as an array of
// per-channel levels; expected channel order comes from a list of enabled
// channels, expected timing from select-change/acceptance arithmetic.
module tb_mux_scan_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [3:0] chan_mask;
  logic [7:0] dwell;
  logic       mux_out, s1, s0, busy;
  logic [3:0] chan_val;
  logic       toggle;
`ifdef MUX_SCAN_FRAME_EN
  logic [3:0] frame_vec;
  logic       frame_done;
`endif

  int vectors     = 0;
  int miscompares = 0;

  mux_scan_ctrl_if sif ();

  mux_scan_ctrl #(.SETTLE_CYC(S), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .chan_mask (chan_mask),
    .dwell     (dwell),
    .mux_out   (mux_out),
    .s1        (s1),
    .s0        (s0),
    .busy      (busy),
    .smp       (sif)
`ifdef MUX_SCAN_FRAME_EN
    ,
    .frame_vec (frame_vec),
    .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  assign mux_out = chan_val[{s1, s0}] ^ toggle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({s1, s0, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_sel_busy: got s=%b busy=%b exp s=00 busy=0", {s1, s0}, busy);
    end
    vectors++;
    if ({sif.smp_valid, sif.smp_data, sif.smp_chan} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_smp: got v=%b d=%b c=%b exp all 0", sif.smp_valid, sif.smp_data, sif.smp_chan);
    end
`ifdef MUX_SCAN_FRAME_EN
    vectors++;
    if ({frame_vec, frame_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_frame: got vec=%b done=%b exp 0", frame_vec, frame_done);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  // Generic scan: nsamp samples, stall cycles of back-pressure per sample
  // (negative = random 0..3), then a stop issued while the last sample is held.
  task automatic test_scan(input string nm, input logic [3:0] mask, input int dwl,
                           input int nsamp, input int stall);
    int en[$];
    int n, k, exp_ch;
    for (int c = 0; c < 4; c++) if (mask[c]) en.push_back(c);
    chan_mask = mask;
    dwell = 8'(dwl);
    sif.smp_ready = 1'b0;
    toggle = 1'b0;
    exp_ch = en[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b exp 1", nm, busy);
    end
    for (int j = 0; j < nsamp; j++) begin
      exp_ch = en[j % en.size()];
      vectors++;
      if ({s1, s0} !== 2'(exp_ch)) begin
        miscompares++;
        $display("FAIL %s sel[%0d]: got %0d exp %0d", nm, j, {s1, s0}, exp_ch);
      end
      n = 0;
      while (sif.smp_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      vectors++;
      if (n !== S + 1) begin
        miscompares++;
        $display("FAIL %s latency[%0d]: got %0d cycles exp %0d", nm, j, n, S + 1);
      end
      vectors++;
      if (sif.smp_chan !== 2'(exp_ch) || sif.smp_data !== chan_val[exp_ch]) begin
        miscompares++;
        $display("FAIL %s sample[%0d]: got chan=%0d data=%b exp chan=%0d data=%b",
                 nm, j, sif.smp_chan, sif.smp_data, exp_ch, chan_val[exp_ch]);
      end
      if (j == nsamp - 1) break;
      k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      repeat (k) begin
        toggle = 1'($urandom);
        tick();
        vectors++;
        if ({sif.smp_valid, sif.smp_data, sif.smp_chan} !== {1'b1, chan_val[exp_ch], 2'(exp_ch)}) begin
          miscompares++;
          $display("FAIL %s hold_stable[%0d]: got v=%b d=%b c=%0d exp v=1 d=%b c=%0d", nm, j,
                   sif.smp_valid, sif.smp_data, sif.smp_chan, chan_val[exp_ch], exp_ch);
        end
      end
      toggle = 1'b0;
      sif.smp_ready = 1'b1;
      tick();
      sif.smp_ready = 1'b0;
      vectors++;
      if (sif.smp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s valid_drop[%0d]: got %b exp 0", nm, j, sif.smp_valid);
      end
      repeat (dwl) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if ({busy, sif.smp_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL %s stop_pending: got busy=%b v=%b exp 1 1", nm, busy, sif.smp_valid);
    end
    sif.smp_ready = 1'b1;
    tick();
    sif.smp_ready = 1'b0;
    tick();
    vectors++;
    if ({busy, sif.smp_valid} !== 2'b00 || {s1, s0} !== 2'(exp_ch)) begin
      miscompares++;
      $display("FAIL %s stop_idle: got busy=%b v=%b s=%0d exp 0 0 %0d", nm, busy, sif.smp_valid, {s1, s0}, exp_ch);
    end
  endtask

  task automatic test_mask_relatch();
    int exp_seq[5] = '{0, 1, 2, 3, 2};
    int n;
    chan_val = 4'($urandom);
    chan_mask = 4'b0011;
    dwell = 8'd0;
    sif.smp_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (sif.smp_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      vectors++;
      if (n >= 40 || sif.smp_chan !== 2'(exp_seq[j]) || sif.smp_data !== chan_val[exp_seq[j]]) begin
        miscompares++;
        $display("FAIL relatch[%0d]: got chan=%0d data=%b wait=%0d exp chan=%0d data=%b",
                 j, sif.smp_chan, sif.smp_data, n, exp_seq[j], chan_val[exp_seq[j]]);
      end
      if (j == 0) chan_mask = 4'b1100;
      if (j == 2) start = 1'b1;
      if (j < 4) begin
        tick();
        start = 1'b0;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sif.smp_ready = 1'b0;
    vectors++;
    if ({busy, sif.smp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL relatch_stop: got busy=%b v=%b exp 0 0", busy, sif.smp_valid);
    end
  endtask

  task automatic test_edge_cases();
    chan_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_mask0: got busy=%b exp 0", busy);
    end
    chan_mask = 4'b1111;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    vectors++;
    if ({busy, sif.smp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL start_stop: got busy=%b v=%b exp 0 0", busy, sif.smp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    chan_val = 4'b1111;
    chan_mask = 4'b1000;
    sif.smp_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({s1, s0, busy, sif.smp_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_settle: got s=%b busy=%b v=%b exp 00 0 0", {s1, s0}, busy, sif.smp_valid);
    end
    chan_mask = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (sif.smp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if ({sif.smp_valid, sif.smp_data, sif.smp_chan} !== 4'b1110) begin
      miscompares++;
      $display("FAIL pre_reset_hold: got v=%b d=%b c=%0d exp 1 1 2", sif.smp_valid, sif.smp_data, sif.smp_chan);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, sif.smp_valid, sif.smp_data, sif.smp_chan, s1, s0} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_in_hold: got busy=%b v=%b d=%b c=%0d s=%b exp all 0",
               busy, sif.smp_valid, sif.smp_data, sif.smp_chan, {s1, s0});
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      chan_val = 4'($urandom);
      test_scan("random", 4'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 5, -1);
    end
  endtask

`ifdef MUX_SCAN_FRAME_EN
  task automatic test_frame();
    int n;
    logic [3:0] m, expv;
    m = 4'b1101;
    chan_val = {1'b1, 1'b0, 1'($urandom), 1'b1};
    expv = chan_val & m;
    chan_mask = m;
    dwell = 8'd0;
    sif.smp_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (frame_done !== 1'b1 || frame_vec !== expv) begin
      miscompares++;
      $display("FAIL frame_vec: got done=%b vec=%b exp done=1 vec=%b", frame_done, frame_vec, expv);
    end
    vectors++;
    if (sif.smp_chan !== 2'd3) begin
      miscompares++;
      $display("FAIL frame_last_chan: got %0d exp 3", sif.smp_chan);
    end
    tick();
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_pulse_width: got %b exp 0", frame_done);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sif.smp_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    chan_mask = 4'b0;
    dwell = 8'd0;
    chan_val = 4'b0;
    toggle = 1'b0;
    sif.smp_ready = 1'b0;
    test_reset();
    chan_val = 4'b1101;
    test_scan("full_scan", 4'b1111, 0, 4, 0);
    chan_val = 4'($urandom);
    test_scan("skip", 4'b0101, 0, 4, 0);
    chan_val = 4'($urandom);
    test_scan("back_pressure", 4'b1111, 3, 3, 10);
    chan_val = 4'($urandom);
    test_scan("single_chan", 4'b0010, 1, 3, 1);
    test_mask_relatch();
    test_edge_cases();
    test_reset_mid();
    test_random();
`ifdef MUX_SCAN_FRAME_EN
    test_frame();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
